// File: rtl/fll_arbiter.sv
// fll_arbiter: round-robin arbiter that shares one FLL instance between NUM_CH
// tracking channels, with start hold, result-tag matching and a WAIT timeout.
`default_nettype none

module fll_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int TAG_W      = 2,
  parameter int START_HOLD = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic              fll_start,
  output logic [TAG_W-1:0]  fll_tag,
  input  logic              fll_result_ready,
  input  logic [TAG_W-1:0]  fll_result_tag,
  output logic [NUM_CH-1:0] done,
  output logic              busy,
  output logic              timeout_err,
  output logic              stray_err,
  output logic              overrun_err
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [TAG_W-1:0]  LAST_RST  = TAG_W'(NUM_CH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [NUM_CH-1:0] pending_q,    pending_d;
  logic [TAG_W-1:0]  last_grant_q, last_grant_d;
  logic [TAG_W-1:0]  tag_q,        tag_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [NUM_CH-1:0] done_q,       done_d;
  logic              timeout_q,    timeout_d;
  logic              stray_q,      stray_d;
  logic              overrun_q,    overrun_d;

  logic              grant_found;
  logic [TAG_W-1:0]  grant_idx;
  logic              grant_fire;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] svc_oh;
  logic [NUM_CH-1:0] busy_mask;
  logic [WAIT_W-1:0] wait_next;
  logic              tag_match;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_CH;
      cand = TAG_W'(idx);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign svc_oh    = (state_q != S_IDLE) ? (NUM_CH'(1) << tag_q) : '0;
  assign busy_mask = pending_q | svc_oh;
  assign tag_match = fll_result_ready && (fll_result_tag == tag_q);
  assign wait_next = wait_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    done_d       = '0;
    timeout_d    = 1'b0;
    stray_d      = 1'b0;
    grant_fire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stray_d = fll_result_ready;
        if (grant_found) begin
          grant_fire   = 1'b1;
          state_d      = S_ISSUE;
          tag_d        = grant_idx;
          last_grant_d = grant_idx;
          hold_cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        stray_d = fll_result_ready;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_WAIT;
          hold_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A match on the cycle the counter reaches TIMEOUT still wins.
        if (tag_match) begin
          state_d    = S_DONE;
          done_d     = NUM_CH'(1) << tag_q;
          wait_cnt_d = '0;
        end else begin
          stray_d = fll_result_ready;
          if (wait_next == WAIT_MAX) begin
            state_d    = S_IDLE;
            timeout_d  = 1'b1;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_next;
          end
        end
      end
      S_DONE: begin
        stray_d = fll_result_ready;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    grant_oh  = grant_fire ? (NUM_CH'(1) << grant_idx) : '0;
    pending_d = (pending_q & ~grant_oh) | (req & ~busy_mask);
    overrun_d = |(req & busy_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      last_grant_q <= LAST_RST;
      tag_q        <= '0;
      hold_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      done_q       <= '0;
      timeout_q    <= 1'b0;
      stray_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      hold_cnt_q   <= hold_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      stray_q      <= stray_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fll_start   = (state_q == S_ISSUE);
  assign fll_tag     = tag_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_q;
  assign stray_err   = stray_q;
  assign overrun_err = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_fll_arbiter.sv
// tb_fll_arbiter: directed, table-driven checks of fll_arbiter with default parameters.
`default_nettype none

module tb_fll_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       fll_start;
  logic [1:0] fll_tag;
  logic       fll_result_ready;
  logic [1:0] fll_result_tag;
  logic [3:0] done;
  logic       busy;
  logic       timeout_err;
  logic       stray_err;
  logic       overrun_err;

  int total = 0;
  int bad   = 0;

  fll_arbiter #(
    .NUM_CH(4), .TAG_W(2), .START_HOLD(8), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .fll_start(fll_start), .fll_tag(fll_tag),
    .fll_result_ready(fll_result_ready), .fll_result_tag(fll_result_tag),
    .done(done), .busy(busy), .timeout_err(timeout_err),
    .stray_err(stray_err), .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] req;
    logic [1:0] tag;
    int         dly;
    logic [3:0] exp_done;
  } op_t;

  op_t ops[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue_phase(input logic [1:0] exp_tag, input int exp_len, output int waited);
    int n;
    waited = 0;
    while (fll_start !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    chk("start_seen", 32'(fll_start), 1);
    n = 0;
    while (fll_start === 1'b1 && n < 100) begin
      chk("issue_tag", 32'(fll_tag), 32'(exp_tag));
      n++;
      step();
    end
    chk("start_len", n, exp_len);
    chk("wait_busy", 32'(busy), 1);
  endtask

  task automatic finish_op(input logic [1:0] tag, input int dly, input logic [3:0] exp_done);
    repeat (dly) step();
    chk("no_early_done", 32'(done), 0);
    chk("still_waiting", 32'(busy), 1);
    fll_result_ready = 1'b1;
    fll_result_tag   = tag;
    step();
    fll_result_ready = 1'b0;
    chk("done", 32'(done), 32'(exp_done));
    chk("done_busy", 32'(busy), 1);
    chk("done_no_tout", 32'(timeout_err), 0);
    step();
    chk("done_clear", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int w;
    int starts;

    ops[0] = '{req: 4'b0001, tag: 2'd0, dly: 20,   exp_done: 4'b0001};
    ops[1] = '{req: 4'b0100, tag: 2'd2, dly: 0,    exp_done: 4'b0100};
    ops[2] = '{req: 4'b1000, tag: 2'd3, dly: 5,    exp_done: 4'b1000};
    ops[3] = '{req: 4'b0010, tag: 2'd1, dly: 1022, exp_done: 4'b0010};

    reset = 1'b0;
    req = '0;
    fll_result_ready = 1'b0;
    fll_result_tag = '0;

    #3;
    chk("rst_start", 32'(fll_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_errs", {29'd0, timeout_err, stray_err, overrun_err}, 0);
    #19 reset = 1'b1;
    step();
    chk("post_rst_tag", 32'(fll_tag), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // All four channels at once: served 0,1,2,3, then 0 and 2 requested later.
    req = 4'b1111;
    step();
    req = '0;
    for (int i = 0; i < 4; i++) begin
      issue_phase(2'(i), 8, w);
      chk("rr_spacing", w, 1);
      if (i == 3) begin
        req = 4'b0101;
        step();
        req = '0;
        chk("rr_no_overrun", 32'(overrun_err), 0);
      end
      finish_op(2'(i), 2, 4'(1 << i));
    end
    issue_phase(2'd0, 8, w);
    finish_op(2'd0, 1, 4'b0001);
    issue_phase(2'd2, 8, w);
    chk("rr_spacing2", w, 1);
    finish_op(2'd2, 1, 4'b0100);

    // Single-channel transactions, including a result on the last WAIT cycle.
    for (int i = 0; i < 4; i++) begin
      req = ops[i].req;
      step();
      req = '0;
      issue_phase(ops[i].tag, 8, w);
      chk("row_grant_delay", w, 1);
      finish_op(ops[i].tag, ops[i].dly, ops[i].exp_done);
    end

    // Wrong result tag is ignored, right tag next cycle completes.
    req = 4'b0010;
    step();
    req = '0;
    issue_phase(2'd1, 8, w);
    repeat (2) step();
    fll_result_ready = 1'b1;
    fll_result_tag   = 2'd2;
    step();
    chk("wrong_tag_stray", 32'(stray_err), 1);
    chk("wrong_tag_done", 32'(done), 0);
    chk("wrong_tag_busy", 32'(busy), 1);
    fll_result_tag = 2'd1;
    step();
    fll_result_ready = 1'b0;
    chk("right_tag_done", 32'(done), 4'b0010);
    chk("right_tag_stray", 32'(stray_err), 0);
    step();

    // Timeout on channel 3 while channel 0 waits.
    req = 4'b1000;
    step();
    req = '0;
    issue_phase(2'd3, 8, w);
    req = 4'b0001;
    step();
    req = '0;
    repeat (1021) step();
    chk("tout_not_yet", 32'(timeout_err), 0);
    chk("tout_busy_before", 32'(busy), 1);
    step();
    chk("tout_pulse", 32'(timeout_err), 1);
    chk("tout_no_done", 32'(done), 0);
    chk("tout_idle", 32'(busy), 0);
    issue_phase(2'd0, 8, w);
    chk("tout_next_grant", w, 1);
    chk("tout_cleared", 32'(timeout_err), 0);
    finish_op(2'd0, 3, 4'b0001);

    // Overrun: repeat request for a pending channel and for the one in service.
    req = 4'b0001;
    step();
    req = 4'b0010;
    step();
    chk("ovr_first_ok", 32'(overrun_err), 0);
    chk("ovr_grant0", 32'(fll_tag), 0);
    step();
    chk("ovr_pending", 32'(overrun_err), 1);
    req = 4'b0001;
    step();
    req = '0;
    chk("ovr_in_service", 32'(overrun_err), 1);
    issue_phase(2'd0, 6, w);
    chk("ovr_cleared", 32'(overrun_err), 0);
    finish_op(2'd0, 4, 4'b0001);
    issue_phase(2'd1, 8, w);
    finish_op(2'd1, 0, 4'b0010);
    starts = 0;
    repeat (30) begin
      step();
      if (fll_start) starts++;
    end
    chk("ovr_served_once", starts, 0);
    chk("ovr_idle", 32'(busy), 0);

    // Stray in ISSUE, then reset mid-ISSUE with channel 0 still pending.
    req = 4'b0101;
    step();
    req = '0;
    step();
    chk("rst_seq_start", 32'(fll_start), 1);
    chk("rst_seq_tag", 32'(fll_tag), 2);
    fll_result_ready = 1'b1;
    fll_result_tag   = 2'd2;
    step();
    fll_result_ready = 1'b0;
    chk("issue_stray", 32'(stray_err), 1);
    chk("issue_stray_start", 32'(fll_start), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_start", 32'(fll_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_tag", 32'(fll_tag), 0);
    chk("mid_rst_stray", 32'(stray_err), 0);
    #2 reset = 1'b1;
    starts = 0;
    repeat (20) begin
      step();
      if (fll_start) starts++;
    end
    chk("rst_pending_cleared", starts, 0);
    fll_result_ready = 1'b1;
    fll_result_tag   = 2'd2;
    step();
    fll_result_ready = 1'b0;
    chk("post_rst_stray", 32'(stray_err), 1);
    chk("post_rst_no_done", 32'(done), 0);
    step();
    chk("post_rst_stray_clr", 32'(stray_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
